// File: rtl/accumulator_sequencer_if.sv
// Operation/ALU bus for the accumulator sequencer.
// slave = sequencer side, master = controller plus external ALU side.
interface accumulator_sequencer_if;
    logic       start;
    logic       op;
    logic [3:0] operand;
    logic       acc_wr;
    logic       clc;
    logic [3:0] data_bus;
    logic       carry_out;
    logic [3:0] A;
    logic [3:0] B;
    logic       ALU_operation;
    logic       ALU_enable;
    logic       carry_flag;
    logic       busy;
    logic       done;

    modport slave (
        input  start, op, operand, acc_wr, clc, data_bus, carry_out,
        output A, B, ALU_operation, ALU_enable, carry_flag, busy, done
    );

    modport master (
        output start, op, operand, acc_wr, clc, data_bus, carry_out,
        input  A, B, ALU_operation, ALU_enable, carry_flag, busy, done
    );
endinterface

// File: rtl/accumulator_sequencer.sv
// Sequences one add/subtract through an external 4-bit ALU.
// Control outputs are Moore decodes of the state register.
module accumulator_sequencer (
    input  logic                          clk,
    input  logic                          reset,
    accumulator_sequencer_if.slave        bus
);
    localparam int unsigned W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   acc;
    logic [W-1:0]   tmp;
    logic           opr;
    logic           carry;
    logic           alu_operation_c;
    logic           alu_enable_c;
    logic           busy_c;
    logic           done_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded controls
    always_comb begin
        state_nxt       = state;
        alu_operation_c = 1'b0;
        alu_enable_c    = 1'b0;
        busy_c          = 1'b1;
        done_c          = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_operation_c = opr;
                state_nxt       = WB;
            end
            WB: begin
                alu_operation_c = opr;
                alu_enable_c    = 1'b1;
                state_nxt       = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture in IDLE, write back the ALU result in WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= W'(0);
            tmp   <= W'(0);
            opr   <= 1'b0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tmp <= bus.operand;
                        opr <= bus.op;
                    end else begin
                        if (bus.acc_wr) begin
                            acc <= bus.operand;
                        end
                        if (bus.clc) begin
                            carry <= 1'b0;
                        end
                    end
                end
                WB: begin
                    acc   <= bus.data_bus;
                    carry <= bus.carry_out;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.A             = acc;
    assign bus.B             = tmp;
    assign bus.carry_flag    = carry;
    assign bus.ALU_operation = alu_operation_c;
    assign bus.ALU_enable    = alu_enable_c;
    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
endmodule

// File: doc/accumulator_sequencer.md
ACCUMULATOR_SEQUENCER -- requirements
Module: accumulator_sequencer

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin one ALU operation; sampled only in IDLE.
- op  input  1  0 = add, 1 = subtract; sampled with start.
- operand  input  4  B operand, sampled with start; also the load value for acc_wr.
- acc_wr  input  1  load ACC from operand; IDLE only.
- clc  input  1  clear carry_flag; IDLE only.
- data_bus  input  4  ALU result, valid while ALU_enable = 1.
- carry_out  input  1  ALU carry, valid while ALU_enable = 1.
- A  output  4  accumulator (ACC) contents; drives ALU A.
- B  output  4  temp register (TMP) contents; drives ALU B.
- ALU_operation  output  1  ALU add/subtract select.
- ALU_enable  output  1  enables the ALU onto data_bus.
- carry_flag  output  1  latched carry / no-borrow flag.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle completion pulse.
REQ-002 SHALL have no parameters; all datapaths are 4 bits.

Function
REQ-003 SHALL implement a Moore FSM with states IDLE, EXEC, WB and DONE; all outputs SHALL come from registers or from decoding the state register only.
REQ-004 IDLE with start=1: TMP<=operand, OPR<=op, next state EXEC; acc_wr and clc in the same cycle SHALL be ignored.
REQ-005 IDLE with start=0: acc_wr=1 -> ACC<=operand; clc=1 -> carry_flag<=0; both may act in the same cycle; state SHALL remain IDLE.
REQ-006 EXEC: ALU_operation=OPR, ALU_enable=0 (settle cycle); next state WB unconditionally.
REQ-007 WB: ALU_operation=OPR, ALU_enable=1; at the clock edge ACC<=data_bus and carry_flag<=carry_out; next state DONE.
REQ-008 DONE: done=1 for exactly one cycle, ALU_enable=0; next state IDLE.
REQ-009 ALU_operation SHALL be 0 in IDLE and DONE; ALU_enable SHALL be 1 only in WB.
REQ-010 Latency: start sampled at edge N -> ACC and carry_flag updated at edge N+2 -> done high during cycle N+3 -> next start accepted at edge N+4 (done-cycle start is ignored).
REQ-011 start, acc_wr and clc SHALL be ignored while busy=1; TMP and OPR SHALL hold constant from EXEC through DONE.
REQ-012 Carry semantics come from the ALU: add -> carry = bit 4 of A+B; subtract -> carry = 1 means no borrow (A >= B). Results wrap modulo 16.
REQ-013 A SHALL equal ACC and B SHALL equal TMP at all times.

Reset
REQ-014 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, ACC=0, TMP=0, OPR=0, carry_flag=0, busy=0, done=0, ALU_operation=0, ALU_enable=0.
REQ-015 Reset asserted in any state, including WB, SHALL abort the operation with no ACC or carry update; ALU_enable SHALL deassert combinationally with reset.
REQ-016 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-017 acc_wr with operand=5, then start, op=0, operand=3 -> ALU_enable high exactly one cycle, done at N+3, A=8, carry_flag=0.
REQ-018 ACC=9, start add operand=9 -> A=2, carry_flag=1; then clc -> carry_flag=0, A stays 2.
REQ-019 ACC=3, start sub operand=5 -> ALU_operation=1 in EXEC and WB, A=E, carry_flag=0; ACC=7 sub 2 -> A=5, carry_flag=1.
REQ-020 start or acc_wr pulsed during EXEC, WB or DONE -> ignored; ACC, TMP and the done timing are unchanged.
REQ-021 reset asserted mid-WB with ACC=4 and a pending result of C -> A=0, ALU_enable=0 immediately with no clock edge, busy=0, done never pulses.
REQ-022 Simultaneous start, acc_wr and clc in IDLE -> only the operation starts; carry_flag holds until WB.
